gp_fifo: RTL and testbench

//  General-purpose synchronous FIFO for NoC network-interface buffering of flits/words.

---
 rtl/gp_fifo.sv | 96 +++++++++
 tb/tb_gp_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gp_fifo.sv
// Single-clock FIFO with registered read data, occupancy and over/underflow error flag.
// Sits between the NI control logic and the flit datapath.
module gp_fifo #(
    parameter int unsigned LENGTH   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned MSB_SLOT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_en,
    input  logic                read_en,
    input  logic [DEPTH-1:0]    data_in,
    output logic [DEPTH-1:0]    data_out,
    output logic                error,
    output logic                full,
    output logic                empty,
    output logic [MSB_SLOT:0]   ocup
);

    localparam int unsigned PW = MSB_SLOT + 1;
    localparam int unsigned CW = MSB_SLOT + 2;

    logic [DEPTH-1:0] mem_q [LENGTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [DEPTH-1:0] data_out_q, data_out_d;
    logic             error_q,  error_d;

    logic             full_c;
    logic             empty_c;
    logic             do_wr_c;
    logic             do_rd_c;
    logic             illegal_c;

    // Status decode; at full a concurrent read frees the slot the write needs.
    always_comb begin
        full_c    = (count_q == CW'(LENGTH));
        empty_c   = (count_q == '0);
        do_wr_c   = write_en && (!full_c || read_en);
        do_rd_c   = read_en && !empty_c;
        illegal_c = (write_en && full_c && !read_en) || (read_en && empty_c);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        error_d    = illegal_c;

        if (do_wr_c) begin
            wr_ptr_d = (wr_ptr_q == PW'(LENGTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_rd_c) begin
            rd_ptr_d   = (rd_ptr_q == PW'(LENGTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        unique case ({do_wr_c, do_rd_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    // Storage is never reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign error    = error_q;
    assign full     = full_c;
    assign empty    = empty_c;
    assign ocup     = full_c ? '1 : count_q[PW-1:0];

endmodule

// File: tb/tb_gp_fifo.sv
// Directed self-checking bench for gp_fifo: order, concurrency, full/wrap,
// underflow and asynchronous reset behaviour.
module tb_gp_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic        read_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        error;
    logic        full;
    logic        empty;
    logic [4:0]  ocup;

    int n_assert = 0;
    int n_fail   = 0;

    gp_fifo #(.LENGTH(32), .DEPTH(32), .MSB_SLOT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .error    (error),
        .full     (full),
        .empty    (empty),
        .ocup     (ocup)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp_ocup,
                                input logic exp_full, input logic exp_empty, input logic exp_err);
        check({tag, ".ocup"},  32'(ocup),  exp_ocup);
        check({tag, ".full"},  32'(full),  32'(exp_full));
        check({tag, ".empty"}, 32'(empty), 32'(exp_empty));
        check({tag, ".error"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        // 1: reset held with a write request pending
        reset    = 1'b0;
        write_en = 1'b1;
        read_en  = 1'b0;
        data_in  = 32'hDEADBEEF;
        step();
        step();
        check_status("rst", 0, 1'b0, 1'b1, 1'b0);
        check("rst.data_out", data_out, 32'h0);
        write_en = 1'b0;
        reset    = 1'b1;
        step();
        check_status("rst_rel", 0, 1'b0, 1'b1, 1'b0);

        // 2: fill and drain order
        write_en = 1'b1;
        data_in = 32'h0101A5A5; step();
        data_in = 32'h0000BBBB; step();
        data_in = 32'h00010001; step();
        write_en = 1'b0;
        check_status("fill3", 3, 1'b0, 1'b0, 1'b0);
        read_en = 1'b1;
        step(); check("drain0", data_out, 32'h0101A5A5);
        step(); check("drain1", data_out, 32'h0000BBBB);
        step(); check("drain2", data_out, 32'h00010001);
        read_en = 1'b0;
        check_status("drained", 0, 1'b0, 1'b1, 1'b0);
        step();
        check("hold", data_out, 32'h00010001);

        // 3: concurrent read+write at normal occupancy
        write_en = 1'b1;
        data_in = 32'h0101A5A5; step();
        data_in = 32'h0000BBBB; step();
        data_in = 32'h00010001; step();
        read_en = 1'b1;
        data_in = 32'h0100CCCC; step();
        check("rw.data_out", data_out, 32'h0101A5A5);
        check_status("rw", 3, 1'b0, 1'b0, 1'b0);
        write_en = 1'b0;
        step(); check("rw_d0", data_out, 32'h0000BBBB);
        step(); check("rw_d1", data_out, 32'h00010001);
        step(); check("rw_d2", data_out, 32'h0100CCCC);
        read_en = 1'b0;
        check_status("rw_end", 0, 1'b0, 1'b1, 1'b0);

        // 4: full, overflow, read+write at full, drain across the pointer wrap
        write_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            data_in = 32'(i);
            step();
        end
        write_en = 1'b0;
        check_status("full", 31, 1'b1, 1'b0, 1'b0);
        write_en = 1'b1;
        data_in  = 32'h00000BAD;
        step();
        write_en = 1'b0;
        check_status("ovf", 31, 1'b1, 1'b0, 1'b1);
        step();
        check_status("ovf_clr", 31, 1'b1, 1'b0, 1'b0);
        write_en = 1'b1;
        read_en  = 1'b1;
        data_in  = 32'h00000100;
        step();
        write_en = 1'b0;
        check("full_rw.data_out", data_out, 32'h0);
        check_status("full_rw", 31, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 32; i++) begin
            step();
            check($sformatf("wrap%0d", i), data_out, 32'(i));
        end
        step();
        check("wrap_last", data_out, 32'h00000100);
        read_en = 1'b0;
        check_status("wrap_end", 0, 1'b0, 1'b1, 1'b0);

        // 5: underflow, alone and with a concurrent write
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        check_status("udf", 0, 1'b0, 1'b1, 1'b1);
        check("udf.data_out", data_out, 32'h00000100);
        step();
        check_status("udf_clr", 0, 1'b0, 1'b1, 1'b0);
        write_en = 1'b1;
        read_en  = 1'b1;
        data_in  = 32'h00000055;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        check_status("udf_rw", 1, 1'b0, 1'b0, 1'b1);
        check("udf_rw.data_out", data_out, 32'h00000100);
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        check("udf_rw_rd", data_out, 32'h00000055);
        check_status("udf_rw_rd", 0, 1'b0, 1'b1, 1'b0);

        // 6: asynchronous reset between edges with 5 entries
        write_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 32'hA000 + 32'(i);
            step();
        end
        write_en = 1'b0;
        check_status("pre_arst", 5, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_status("arst", 0, 1'b0, 1'b1, 1'b0);
        check("arst.data_out", data_out, 32'h0);
        step();
        reset = 1'b1;
        step();
        check_status("arst_rel", 0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
